// File: rtl/dsa_simd_lane_feeder.sv
// Lane feeder for the N-lane bilinear datapath: walks the destination raster N pixels at a time,
// gathers four clamped source neighbours per lane, runs the datapath and writes the results back.
module dsa_simd_lane_feeder #(
  parameter int N     = 4,
  parameter int SRC_W = 64,
  parameter int SRC_H = 64,
  parameter int DST_W = 128,
  parameter int DST_H = 128
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [15:0]                      step_x,
  input  logic [15:0]                      step_y,
  output logic                             busy,
  output logic                             done,
  output logic                             src_rd,
  output logic [$clog2(SRC_W*SRC_H)-1:0]   src_addr,
  input  logic [7:0]                       src_data,
  output logic                             dp_start,
  output logic [8*N-1:0]                   dp_p00,
  output logic [8*N-1:0]                   dp_p01,
  output logic [8*N-1:0]                   dp_p10,
  output logic [8*N-1:0]                   dp_p11,
  output logic [16*N-1:0]                  dp_a,
  output logic [16*N-1:0]                  dp_b,
  input  logic [8*N-1:0]                   dp_pixel_out,
  input  logic                             dp_done,
  output logic                             dst_wr,
  output logic [$clog2(DST_W*DST_H)-1:0]   dst_addr,
  output logic [7:0]                       dst_data
);

  localparam int SA_W   = $clog2(SRC_W*SRC_H);
  localparam int DA_W   = $clog2(DST_W*DST_H);
  localparam int TOTAL  = DST_W*DST_H;
  localparam int PIX_W  = $clog2(TOTAL+1);
  localparam int LANE_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_WRITE = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]        state;
  logic [LANE_W-1:0] lane;
  logic [1:0]        sub;
  logic [PIX_W-1:0]  pix;
  logic [PIX_W-1:0]  base;
  logic [15:0]       ox;
  logic [23:0]       fx;
  logic [23:0]       fy;
  logic [15:0]       sx;
  logic [15:0]       sy;
  logic              rd_q;
  logic [LANE_W-1:0] rd_lane;
  logic [1:0]        rd_sub;
  logic [LANE_W-1:0] wr_lane;
  logic [8*N-1:0]    pix_q;

  logic [16:0]       xi_e, xi1, yi_e, yi1, limx, limy;
  logic [16:0]       x0, x1, y0, y1, xsel, ysel;
  logic              last_lane;
  logic              wr_last;
  logic              frame_end;
  logic              clr;

  always_comb begin
    limx = 17'(SRC_W-1);
    limy = 17'(SRC_H-1);
    xi_e = {1'b0, fx[23:8]};
    yi_e = {1'b0, fy[23:8]};
    xi1  = xi_e + 17'd1;
    yi1  = yi_e + 17'd1;
    x0   = (xi_e > limx) ? limx : xi_e;
    x1   = (xi1  > limx) ? limx : xi1;
    y0   = (yi_e > limy) ? limy : yi_e;
    y1   = (yi1  > limy) ? limy : yi1;
    // sub encodes the neighbour: bit0 selects x+1, bit1 selects y+1
    xsel = sub[0] ? x1 : x0;
    ysel = sub[1] ? y1 : y0;
  end

  assign last_lane = (lane == LANE_W'(N-1)) || (pix == PIX_W'(TOTAL-1));
  assign wr_last   = (wr_lane == LANE_W'(N-1)) ||
                     (DA_W'(base) + DA_W'(wr_lane) == DA_W'(TOTAL-1));
  assign frame_end = (pix == PIX_W'(TOTAL));
  assign clr       = ((state == S_IDLE) && start) ||
                     ((state == S_WRITE) && wr_last && !frame_end);

  always_comb begin
    busy     = (state != S_IDLE);
    done     = (state == S_DONE);
    dp_start = (state == S_ISSUE);
    src_rd   = (state == S_FETCH);
    src_addr = '0;
    dst_wr   = (state == S_WRITE);
    dst_addr = '0;
    dst_data = '0;
    if (state == S_FETCH)
      src_addr = SA_W'(ysel) * SA_W'(SRC_W) + SA_W'(xsel);
    if (state == S_WRITE) begin
      dst_addr = DA_W'(base) + DA_W'(wr_lane);
      dst_data = pix_q[int'(wr_lane)*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      lane    <= '0;
      sub     <= '0;
      pix     <= '0;
      base    <= '0;
      ox      <= '0;
      fx      <= '0;
      fy      <= '0;
      sx      <= '0;
      sy      <= '0;
      rd_q    <= 1'b0;
      rd_lane <= '0;
      rd_sub  <= '0;
      wr_lane <= '0;
      pix_q   <= '0;
      dp_p00  <= '0;
      dp_p01  <= '0;
      dp_p10  <= '0;
      dp_p11  <= '0;
      dp_a    <= '0;
      dp_b    <= '0;
    end else begin
      rd_q    <= src_rd;
      rd_lane <= lane;
      rd_sub  <= sub;

      // invalid lanes of a partial group keep these zeros
      if (clr) begin
        dp_p00 <= '0;
        dp_p01 <= '0;
        dp_p10 <= '0;
        dp_p11 <= '0;
        dp_a   <= '0;
        dp_b   <= '0;
      end

      // read data lands one cycle after its strobe, so it belongs to last cycle's slot
      if (rd_q) begin
        case (rd_sub)
          2'd0:    dp_p00[int'(rd_lane)*8 +: 8] <= src_data;
          2'd1:    dp_p01[int'(rd_lane)*8 +: 8] <= src_data;
          2'd2:    dp_p10[int'(rd_lane)*8 +: 8] <= src_data;
          default: dp_p11[int'(rd_lane)*8 +: 8] <= src_data;
        endcase
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            sx    <= step_x;
            sy    <= step_y;
            fx    <= '0;
            fy    <= '0;
            ox    <= '0;
            pix   <= '0;
            base  <= '0;
            lane  <= '0;
            sub   <= '0;
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          sub <= sub + 2'd1;
          if (sub == 2'd0) begin
            dp_a[int'(lane)*16 +: 16] <= {8'h00, fx[7:0]};
            dp_b[int'(lane)*16 +: 16] <= {8'h00, fy[7:0]};
          end
          if (sub == 2'd3) begin
            pix  <= pix + PIX_W'(1);
            lane <= lane + LANE_W'(1);
            if (ox == 16'(DST_W-1)) begin
              ox <= '0;
              fx <= '0;
              fy <= fy + {8'h00, sy};
            end else begin
              ox <= ox + 16'd1;
              fx <= fx + {8'h00, sx};
            end
            if (last_lane)
              state <= S_DRAIN;
          end
        end
        S_DRAIN: state <= S_ISSUE;
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (dp_done) begin
            pix_q   <= dp_pixel_out;
            wr_lane <= '0;
            state   <= S_WRITE;
          end
        end
        S_WRITE: begin
          wr_lane <= wr_lane + LANE_W'(1);
          if (wr_last) begin
            if (frame_end) begin
              state <= S_DONE;
            end else begin
              base  <= pix;
              lane  <= '0;
              sub   <= '0;
              state <= S_FETCH;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsa_simd_lane_feeder.sv
// Scoreboard bench for dsa_simd_lane_feeder: 4x4 source, 3x3 destination, 4 lanes, so every frame
// ends on a one-lane partial group and groups straddle destination rows.
module tb_dsa_simd_lane_feeder;

  localparam int N   = 4;
  localparam int SW  = 4;
  localparam int SH  = 4;
  localparam int DW  = 3;
  localparam int DH  = 3;
  localparam int TOT = DW*DH;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] step_x, step_y;
  logic        busy, done, src_rd, dp_start, dp_done, dst_wr;
  logic [3:0]  src_addr, dst_addr;
  logic [7:0]  src_data, dst_data;
  logic [31:0] dp_p00, dp_p01, dp_p10, dp_p11, dp_pixel_out;
  logic [63:0] dp_a, dp_b;

  dsa_simd_lane_feeder #(.N(N), .SRC_W(SW), .SRC_H(SH), .DST_W(DW), .DST_H(DH)) dut (
    .clk(clk), .rst(rst), .start(start), .step_x(step_x), .step_y(step_y),
    .busy(busy), .done(done), .src_rd(src_rd), .src_addr(src_addr), .src_data(src_data),
    .dp_start(dp_start), .dp_p00(dp_p00), .dp_p01(dp_p01), .dp_p10(dp_p10), .dp_p11(dp_p11),
    .dp_a(dp_a), .dp_b(dp_b), .dp_pixel_out(dp_pixel_out), .dp_done(dp_done),
    .dst_wr(dst_wr), .dst_addr(dst_addr), .dst_data(dst_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] p00, p01, p10, p11;
    logic [63:0] a, b;
  } dp_t;
  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  logic [3:0] exp_rd_q[$];
  dp_t        exp_dp_q[$];
  wr_t        exp_wr_q[$];
  logic [7:0] src_mem[16];
  logic [7:0] dst_mem[TOT];

  int n_checks = 0;
  int n_fail   = 0;
  int rd_count, wr_count, dp_starts, done_count;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] bilin(input logic [7:0] p00, p01, p10, p11,
                                       input logic [15:0] a, b);
    int unsigned ia, ib, s;
    ia = a;
    ib = b;
    s = p00*(256-ia)*(256-ib) + p01*ia*(256-ib) + p10*(256-ia)*ib + p11*ia*ib;
    return 8'(s >> 16);
  endfunction

  // source RAM: one-cycle read latency
  always @(posedge clk)
    if (src_rd) src_data <= src_mem[src_addr];

  // datapath stub: bilinear per lane after a programmable latency
  int   dp_delay = 2;
  int   dp_cnt;
  logic dp_run;
  logic stub_done;
  logic extra_done = 1'b0;
  assign dp_done = stub_done | extra_done;

  always @(posedge clk) begin
    stub_done <= 1'b0;
    if (!rst) begin
      dp_run <= 1'b0;
    end else if (dp_start) begin
      dp_run <= 1'b1;
      dp_cnt <= dp_delay;
    end else if (dp_run) begin
      if (dp_cnt <= 1) begin
        logic [31:0] r;
        for (int l = 0; l < N; l++)
          r[l*8 +: 8] = bilin(dp_p00[l*8 +: 8], dp_p01[l*8 +: 8], dp_p10[l*8 +: 8],
                              dp_p11[l*8 +: 8], dp_a[l*16 +: 16], dp_b[l*16 +: 16]);
        dp_pixel_out <= r;
        stub_done    <= 1'b1;
        dp_run       <= 1'b0;
      end else begin
        dp_cnt <= dp_cnt - 1;
      end
    end
  end

  // monitors sample on the falling edge
  dp_t  hold_d;
  logic in_wait = 1'b0;

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (src_rd) begin
        rd_count++;
        check("src_rd_expected", 128'(exp_rd_q.size() != 0), 128'(1));
        if (exp_rd_q.size() != 0) check("src_addr", src_addr, exp_rd_q.pop_front());
      end
      if (in_wait && !dp_start) begin
        check("hold_p", {dp_p00, dp_p01, dp_p10, dp_p11}, {hold_d.p00, hold_d.p01, hold_d.p10, hold_d.p11});
        check("hold_ab", {dp_a, dp_b}, {hold_d.a, hold_d.b});
        if (dp_done) in_wait = 1'b0;
      end
      if (dp_start) begin
        dp_starts++;
        check("dp_start_expected", 128'(exp_dp_q.size() != 0), 128'(1));
        if (exp_dp_q.size() != 0) begin
          hold_d = exp_dp_q.pop_front();
          check("dp_p", {dp_p00, dp_p01, dp_p10, dp_p11}, {hold_d.p00, hold_d.p01, hold_d.p10, hold_d.p11});
          check("dp_a", dp_a, hold_d.a);
          check("dp_b", dp_b, hold_d.b);
          in_wait = 1'b1;
        end
      end
      if (dst_wr) begin
        wr_count++;
        if (dst_addr < 4'(TOT)) dst_mem[dst_addr] = dst_data;
        check("dst_wr_expected", 128'(exp_wr_q.size() != 0), 128'(1));
        if (exp_wr_q.size() != 0) begin
          wr_t w;
          w = exp_wr_q.pop_front();
          check("dst_addr", dst_addr, w.addr);
          check("dst_data", dst_data, w.data);
        end
      end
      if (done) done_count++;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic build_frame(input logic [15:0] sx, input logic [15:0] sy);
    for (int g = 0; g < (TOT+N-1)/N; g++) begin
      dp_t d;
      d = '{default: '0};
      for (int l = 0; l < N; l++) begin
        int pix, ox, oy, xi, yi, x0, x1, y0, y1;
        logic [23:0] fx, fy;
        logic [7:0]  v00, v01, v10, v11;
        wr_t w;
        pix = g*N + l;
        if (pix < TOT) begin
          ox = pix % DW;
          oy = pix / DW;
          fx = 24'(ox * int'(sx));
          fy = 24'(oy * int'(sy));
          xi = int'(fx[23:8]);
          yi = int'(fy[23:8]);
          x0 = (xi   > SW-1) ? SW-1 : xi;
          x1 = (xi+1 > SW-1) ? SW-1 : xi+1;
          y0 = (yi   > SH-1) ? SH-1 : yi;
          y1 = (yi+1 > SH-1) ? SH-1 : yi+1;
          exp_rd_q.push_back(4'(y0*SW + x0));
          exp_rd_q.push_back(4'(y0*SW + x1));
          exp_rd_q.push_back(4'(y1*SW + x0));
          exp_rd_q.push_back(4'(y1*SW + x1));
          v00 = src_mem[y0*SW + x0];
          v01 = src_mem[y0*SW + x1];
          v10 = src_mem[y1*SW + x0];
          v11 = src_mem[y1*SW + x1];
          d.p00[l*8 +: 8]  = v00;
          d.p01[l*8 +: 8]  = v01;
          d.p10[l*8 +: 8]  = v10;
          d.p11[l*8 +: 8]  = v11;
          d.a[l*16 +: 16]  = {8'h00, fx[7:0]};
          d.b[l*16 +: 16]  = {8'h00, fy[7:0]};
          w.addr = 4'(pix);
          w.data = bilin(v00, v01, v10, v11, {8'h00, fx[7:0]}, {8'h00, fy[7:0]});
          exp_wr_q.push_back(w);
        end
      end
      exp_dp_q.push_back(d);
    end
  endtask

  task automatic flush();
    exp_rd_q.delete();
    exp_dp_q.delete();
    exp_wr_q.delete();
    in_wait = 1'b0;
  endtask

  task automatic clear_counts();
    rd_count = 0;
    wr_count = 0;
    dp_starts = 0;
    done_count = 0;
  endtask

  task automatic pulse_start(input logic [15:0] sx, input logic [15:0] sy);
    step_x = sx;
    step_y = sy;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_dp_start();
    for (int i = 0; i < 300; i++) begin
      if (dp_starts != 0) break;
      tick();
    end
    check("dp_start_seen", 128'(dp_starts != 0), 128'(1));
  endtask

  task automatic run_frame(input logic [15:0] sx, input logic [15:0] sy,
                           input int delay, input bit restart);
    clear_counts();
    dp_delay = delay;
    build_frame(sx, sy);
    pulse_start(sx, sy);
    check("busy_after_start", busy, 1'b1);
    if (restart) begin
      wait_dp_start();
      tick(3);
      pulse_start(16'h0100, 16'h0100);
    end
    for (int i = 0; i < 2000; i++) begin
      if (done_count != 0) break;
      tick();
    end
    tick(5);
    check("done_pulses", done_count, 1);
    check("dp_start_pulses", dp_starts, 3);
    check("src_rd_count", rd_count, 4*TOT);
    check("dst_wr_count", wr_count, TOT);
    check("rd_queue_left", exp_rd_q.size(), 0);
    check("wr_queue_left", exp_wr_q.size(), 0);
    check("busy_after_done", busy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    start = 1'b0;
    step_x = '0;
    step_y = '0;
    for (int i = 0; i < 16; i++) src_mem[i] = 8'(i*13 + 7);
    for (int i = 0; i < TOT; i++) dst_mem[i] = '0;
    clear_counts();
    tick(3);
    check("reset_outputs", {busy, done, src_rd, dp_start, dst_wr}, 5'b0);
    check("reset_addrs", {src_addr, dst_addr, dst_data}, 16'h0);
    check("reset_dp", {dp_p00, dp_p01, dp_p10, dp_p11, dp_a[63:0]}, 192'h0);
    rst = 1'b1;
    tick(2);

    // dp_done while idle must do nothing
    extra_done = 1'b1;
    tick();
    extra_done = 1'b0;
    tick(2);
    check("idle_dp_done_busy", busy, 1'b0);

    // identity copy
    run_frame(16'h0100, 16'h0100, 2, 1'b0);
    for (int i = 0; i < TOT; i++)
      check("identity_pixel", dst_mem[i], src_mem[(i/DW)*SW + (i%DW)]);

    // half step, pixel (1,1) blends the 2x2 corner
    src_mem[0] = 8'd100;
    src_mem[1] = 8'd120;
    src_mem[4] = 8'd140;
    src_mem[5] = 8'd160;
    run_frame(16'h0080, 16'h0080, 1, 1'b0);
    check("half_step_pixel_1_1", dst_mem[4], 8'd130);

    // right/bottom edge clamp: column 2 sits at x=3.5, row 2 at y=3.5
    run_frame(16'h01C0, 16'h01C0, 3, 1'b0);
    check("clamp_pixel_2_2", dst_mem[8], src_mem[15]);

    // slow datapath with a stray start during WAIT_DP
    run_frame(16'h0100, 16'h0100, 20, 1'b1);

    // reset mid-FETCH
    clear_counts();
    dp_delay = 2;
    build_frame(16'h0100, 16'h0100);
    pulse_start(16'h0100, 16'h0100);
    tick(5);
    rst = 1'b0;
    flush();
    tick();
    check("fetch_reset_outputs", {busy, done, src_rd, dp_start, dst_wr}, 5'b0);
    tick();
    rst = 1'b1;
    clear_counts();
    tick(60);
    check("fetch_reset_no_reads", rd_count, 0);
    check("fetch_reset_no_done", done_count, 0);

    // reset while waiting on the datapath
    clear_counts();
    dp_delay = 30;
    build_frame(16'h0100, 16'h0100);
    pulse_start(16'h0100, 16'h0100);
    wait_dp_start();
    tick(3);
    rst = 1'b0;
    flush();
    tick(2);
    rst = 1'b1;
    check("wait_reset_busy", busy, 1'b0);
    clear_counts();
    tick(60);
    check("wait_reset_no_writes", wr_count, 0);
    check("wait_reset_no_done", done_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
